// File: rtl/bcd_display_driver_pkg.sv
// rtl/bcd_display_driver_pkg.sv - shared constants, types and helpers for the BCD display driver
// Contents: segment codes (active-high, bit0=a .. bit6=g), FSM state enum,
//           shift count and counter width, BCD nibble width, add-3 helper.
package bcd_display_driver_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int SHIFT_COUNT = 14;
    localparam int CNT_W       = 4;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SHIFT_COUNT - 1);

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after the
    // next doubling, so pre-add 3 to make it carry into the next decade.
    function automatic logic [NIBBLE_W-1:0] add3(input logic [NIBBLE_W-1:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD nibble to seven-segment pattern decoder
// Ports: nibble (BCD digit), blank (force all segments off), dash (force only g lit,
//        takes priority over blank), seg (pattern, bit0=a .. bit6=g, polarity per
//        SEG_ACTIVE_LOW).
module bcd_to_seg
    import bcd_display_driver_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [NIBBLE_W-1:0] nibble,
    input  logic                blank,
    input  logic                dash,
    output logic [6:0]          seg
);

    logic [6:0] code;

    always_comb begin
        code = SEG_BLANK;
        if (dash) begin
            code = SEG_DASH;
        end else if (blank) begin
            code = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    code = SEG_0;
                4'd1:    code = SEG_1;
                4'd2:    code = SEG_2;
                4'd3:    code = SEG_3;
                4'd4:    code = SEG_4;
                4'd5:    code = SEG_5;
                4'd6:    code = SEG_6;
                4'd7:    code = SEG_7;
                4'd8:    code = SEG_8;
                4'd9:    code = SEG_9;
                default: code = SEG_BLANK;
            endcase
        end
        seg = SEG_ACTIVE_LOW ? ~code : code;
    end

endmodule

// File: rtl/bcd_display_driver.sv
// rtl/bcd_display_driver.sv - handshaked binary to four-digit seven-segment driver
// Ports: clk, n_reset (async active-low), binary[31:0] + in_valid / in_ready (accept in IDLE),
//        ones/tens/hundreds/thousands[6:0] (registered segment patterns), ovf (last value
//        exceeded MAX_VALUE), out_valid (one-cycle pulse on new digits).
// Optional feature macro: BCD_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter logic [31:0] MAX_VALUE      = 32'd9999
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] binary,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [6:0]  ones,
    output logic [6:0]  tens,
    output logic [6:0]  hundreds,
    output logic [6:0]  thousands,
    output logic        ovf,
    output logic        out_valid
);

    // All segments off in the configured polarity.
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    state_t             state;
    state_t             state_next;
    logic [13:0]        src;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic               accept;
    logic               load_en;

    logic               blank_th;
    logic               blank_hu;
    logic               blank_te;
    logic [6:0]         seg_ones;
    logic [6:0]         seg_tens;
    logic [6:0]         seg_hundreds;
    logic [6:0]         seg_thousands;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load_en    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Counter starts at SHIFT_COUNT-1, so reaching zero marks the last shift.
                if (cnt == '0) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- shift-and-add-3 engine
    assign bcd_adj = {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            src      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else if (accept) begin
            // Only 14 bits fit four decimal digits; anything wider is caught by
            // the full-width overflow compare and shown as dashes.
            src      <= binary[13:0];
            bcd      <= '0;
            cnt      <= CNT_INIT;
            ovf_pend <= (binary > MAX_VALUE);
        end else if (state == SHIFT) begin
            bcd <= {bcd_adj[14:0], src[13]};
            src <= {src[12:0], 1'b0};
            cnt <= cnt - 1'b1;
        end
    end

    // ---------------------------------------------------------------- digit decode
`ifdef BCD_LEADING_ZERO_BLANK_EN
    // Blanking ripples from the most significant digit; ones is never blanked.
    assign blank_th = (bcd[15:12] == 4'd0);
    assign blank_hu = blank_th && (bcd[11:8] == 4'd0);
    assign blank_te = blank_hu && (bcd[7:4] == 4'd0);
`else
    assign blank_th = 1'b0;
    assign blank_hu = 1'b0;
    assign blank_te = 1'b0;
`endif

    bcd_to_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_ones (
        .nibble (bcd[3:0]),
        .blank  (1'b0),
        .dash   (ovf_pend),
        .seg    (seg_ones)
    );

    bcd_to_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_tens (
        .nibble (bcd[7:4]),
        .blank  (blank_te),
        .dash   (ovf_pend),
        .seg    (seg_tens)
    );

    bcd_to_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_hundreds (
        .nibble (bcd[11:8]),
        .blank  (blank_hu),
        .dash   (ovf_pend),
        .seg    (seg_hundreds)
    );

    bcd_to_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_thousands (
        .nibble (bcd[15:12]),
        .blank  (blank_th),
        .dash   (ovf_pend),
        .seg    (seg_thousands)
    );

    // ---------------------------------------------------------------- output registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ones      <= SEG_OFF;
            tens      <= SEG_OFF;
            hundreds  <= SEG_OFF;
            thousands <= SEG_OFF;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= load_en;
            if (load_en) begin
                ones      <= seg_ones;
                tens      <= seg_tens;
                hundreds  <= seg_hundreds;
                thousands <= seg_thousands;
                ovf       <= ovf_pend;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb/tb_bcd_display_driver.sv - directed self-checking bench for bcd_display_driver
module tb_bcd_display_driver;

    // Hand-derived active-low segment codes (bit0=a .. bit6=g).
    localparam logic [6:0] AL_0     = 7'b1000000;
    localparam logic [6:0] AL_1     = 7'b1111001;
    localparam logic [6:0] AL_2     = 7'b0100100;
    localparam logic [6:0] AL_3     = 7'b0110000;
    localparam logic [6:0] AL_4     = 7'b0011001;
    localparam logic [6:0] AL_5     = 7'b0010010;
    localparam logic [6:0] AL_6     = 7'b0000010;
    localparam logic [6:0] AL_7     = 7'b1111000;
    localparam logic [6:0] AL_8     = 7'b0000000;
    localparam logic [6:0] AL_9     = 7'b0010000;
    localparam logic [6:0] AL_DASH  = 7'b0111111;
    localparam logic [6:0] AL_BLANK = 7'b1111111;

    logic        clk;
    logic        n_reset;
    logic [31:0] binary;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  ones;
    logic [6:0]  tens;
    logic [6:0]  hundreds;
    logic [6:0]  thousands;
    logic        ovf;
    logic        out_valid;

    int checks;
    int failures;

    bcd_display_driver dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .binary    (binary),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and observes 24 cycles after the accept edge N.
    // lat = k of the first negedge after edge N+k where out_valid is high (-1 if none).
    task automatic run_conv(input logic [31:0] v, output int lat, output int pulses);
        @(negedge clk);
        binary   = v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        binary   = 32'hDEAD_BEEF;
        lat      = -1;
        pulses   = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic check_digits(input string name, input logic [6:0] e_th, input logic [6:0] e_hu,
                                input logic [6:0] e_te, input logic [6:0] e_on, input logic e_ovf);
        checks++;
        if ({thousands, hundreds, tens, ones, ovf} !== {e_th, e_hu, e_te, e_on, e_ovf}) begin
            failures++;
            $display("FAIL %s digits th=%b hu=%b te=%b on=%b ovf=%b expected th=%b hu=%b te=%b on=%b ovf=%b",
                     name, thousands, hundreds, tens, ones, ovf, e_th, e_hu, e_te, e_on, e_ovf);
        end
    endtask

    task automatic test_reset();
        n_reset  = 1'b0;
        in_valid = 1'b0;
        binary   = '0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b expected=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b expected=0", out_valid);
        end
        check_digits("reset", AL_BLANK, AL_BLANK, AL_BLANK, AL_BLANK, 1'b0);
    endtask

    task automatic test_basic();
        int lat;
        int pulses;
        run_conv(32'd1234, lat, pulses);
        checks++;
        if (lat !== 15) begin
            failures++;
            $display("FAIL basic_latency got=%0d expected=15", lat);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL basic_pulses got=%0d expected=1", pulses);
        end
        check_digits("basic_1234", AL_1, AL_2, AL_3, AL_4, 1'b0);
    endtask

    task automatic test_boundary();
        int lat;
        int pulses;
        run_conv(32'd9999, lat, pulses);
        check_digits("max_9999", AL_9, AL_9, AL_9, AL_9, 1'b0);
        run_conv(32'd10000, lat, pulses);
        checks++;
        if (lat !== 15 || pulses !== 1) begin
            failures++;
            $display("FAIL ovf_timing lat=%0d pulses=%0d expected lat=15 pulses=1", lat, pulses);
        end
        check_digits("ovf_10000", AL_DASH, AL_DASH, AL_DASH, AL_DASH, 1'b1);
        run_conv(32'd5678, lat, pulses);
        check_digits("after_ovf_5678", AL_5, AL_6, AL_7, AL_8, 1'b0);
        // Low 14 bits are zero: only the full-width compare can flag this.
        run_conv(32'h8001_0000, lat, pulses);
        check_digits("ovf_wide", AL_DASH, AL_DASH, AL_DASH, AL_DASH, 1'b1);
    endtask

    task automatic test_leading_zero();
        int lat;
        int pulses;
        run_conv(32'd42, lat, pulses);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check_digits("lz_42", AL_BLANK, AL_BLANK, AL_4, AL_2, 1'b0);
`else
        check_digits("lz_42", AL_0, AL_0, AL_4, AL_2, 1'b0);
`endif
        run_conv(32'd0, lat, pulses);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check_digits("lz_0", AL_BLANK, AL_BLANK, AL_BLANK, AL_0, 1'b0);
`else
        check_digits("lz_0", AL_0, AL_0, AL_0, AL_0, 1'b0);
`endif
        run_conv(32'd907, lat, pulses);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check_digits("lz_907", AL_BLANK, AL_9, AL_0, AL_7, 1'b0);
`else
        check_digits("lz_907", AL_0, AL_9, AL_0, AL_7, 1'b0);
`endif
    endtask

    task automatic test_busy_ignore();
        int lat;
        int pulses;
        logic rdy_mid;
        logic rdy_end;
        @(negedge clk);
        binary   = 32'd1234;
        in_valid = 1'b1;
        @(posedge clk);
        lat     = -1;
        pulses  = 0;
        rdy_mid = 1'b1;
        rdy_end = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            // In_valid seen at edges N+3..N+14 only.
            in_valid = (k >= 2 && k <= 13);
            binary   = (k >= 2 && k <= 13) ? 32'd5678 : 32'd0;
            if (k == 5) rdy_mid = in_ready;
            if (k == 15) rdy_end = in_ready;
            if (out_valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        checks++;
        if (lat !== 15 || pulses !== 1) begin
            failures++;
            $display("FAIL busy_pulse lat=%0d pulses=%0d expected lat=15 pulses=1", lat, pulses);
        end
        checks++;
        if (rdy_mid !== 1'b0 || rdy_end !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_ready mid=%b end=%b expected mid=0 end=1", rdy_mid, rdy_end);
        end
        check_digits("busy_1234", AL_1, AL_2, AL_3, AL_4, 1'b0);
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        @(negedge clk);
        binary   = 32'd8765;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        n_reset = 1'b0;
        #1;
        check_digits("rst_mid_async", AL_BLANK, AL_BLANK, AL_BLANK, AL_BLANK, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ctrl in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_reset = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL rst_mid_no_pulse got=%0d expected=0", pulses);
        end
        run_conv(32'd8765, lat, pulses);
        checks++;
        if (lat !== 15 || pulses !== 1) begin
            failures++;
            $display("FAIL rst_mid_retry lat=%0d pulses=%0d expected lat=15 pulses=1", lat, pulses);
        end
        check_digits("rst_mid_8765", AL_8, AL_7, AL_6, AL_5, 1'b0);
    endtask

    task automatic test_hold();
        repeat (10) @(negedge clk);
        check_digits("hold", AL_8, AL_7, AL_6, AL_5, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_out_valid got=%b expected=0", out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_leading_zero();
        test_busy_ignore();
        test_reset_mid();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
